// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard unit. A per-register countdown
// scoreboard tracks pending writes from variable-latency producers. From it
// the unit derives the RAW/WAW issue stall and the taken-branch flush, and
// it keeps a saturating count of stalled cycles.
module hazard_scoreboard #(
  parameter  int unsigned REG_AW      = 5,
  parameter  int unsigned NUM_SRC     = 2,
  parameter  int unsigned MAX_LAT     = 4,
  parameter  int unsigned FLUSH_DEPTH = 2,
  localparam int unsigned LATW        = $clog2(MAX_LAT + 1),
  localparam int unsigned NREG        = 2 ** REG_AW
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      issue_valid,
  input  logic                      issue_regwrite,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LATW-1:0]           issue_lat,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_reg,
  input  logic                      stall_ext,
  input  logic                      branch_taken,
  input  logic                      stall_count_clr,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [FLUSH_DEPTH-1:0]    flush,
  output logic [NREG-1:0]           busy_mask,
  output logic [15:0]               stall_count
);

  logic [LATW-1:0] cnt [NREG];
  logic [LATW-1:0] lat_eff;
  logic            raw;
  logic            waw;
  logic            load;

  // Clamp the producer latency to the largest supported bubble count
  always_comb begin
    lat_eff = (issue_lat > LATW'(MAX_LAT)) ? LATW'(MAX_LAT) : issue_lat;
  end

  // RAW: any read source whose register still has a pending write
  always_comb begin
    logic [REG_AW-1:0] sreg;
    raw  = 1'b0;
    sreg = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      sreg = src_reg[i*REG_AW +: REG_AW];
      if (src_valid[i] && (sreg != '0) && (cnt[sreg] != '0))
        raw = 1'b1;
    end
  end

  // WAW: an older write to the same register would complete after this one
  always_comb begin
    waw = issue_valid && issue_regwrite && (issue_rd != '0) &&
          (cnt[issue_rd] > lat_eff);
  end

  // Issue control: branch squash and reset override every stall source
  always_comb begin
    stall      = ~Reset & ~branch_taken &
                 ((issue_valid & (raw | waw)) | stall_ext);
    issue_fire = issue_valid & ~stall & ~branch_taken & ~Reset;
    flush      = {FLUSH_DEPTH{branch_taken & ~Reset}};
    load       = issue_fire && issue_regwrite && (issue_rd != '0) &&
                 (issue_lat != '0);
  end

  // Scoreboard counters: a new issue load wins over the per-cycle decrement
  always_ff @(posedge Clk) begin
    cnt[0] <= '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (Reset)
        cnt[r] <= '0;
      else if (load && (issue_rd == REG_AW'(r)))
        cnt[r] <= lat_eff;
      else if (cnt[r] != '0)
        cnt[r] <= cnt[r] - LATW'(1);
    end
  end

  // Busy flags mirror the nonzero scoreboard counters
  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 0; r < NREG; r++)
      busy_mask[r] = (cnt[r] != '0);
  end

  // Saturating stall-cycle counter; clear has priority over increment
  always_ff @(posedge Clk) begin
    if (Reset || stall_count_clr)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule
